// File: rtl/plru_table.sv
// Tree pseudo-LRU state store for an N-way set-associative cache: one query/touch
// per cycle, victim reported the following cycle, with an init sweep and same-set forwarding.
module plru_table #(
    parameter int SETS  = 64,
    parameter int WAYS  = 4,
    localparam int IDX_W  = $clog2(SETS),
    localparam int WAY_W  = $clog2(WAYS),
    localparam int TREE_W = WAYS - 1
) (
    input  logic             clk,
    input  logic             rstn,
    output logic             init_done,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [IDX_W-1:0] req_set,
    input  logic             req_touch,
    input  logic [WAY_W-1:0] req_way,
    output logic             resp_valid,
    output logic [WAY_W-1:0] resp_victim
);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Tree bit k-1 holds heap node k; extending with a dummy bit 0 lets nodes index directly.
    function automatic logic [WAY_W-1:0] tree_victim(input logic [TREE_W-1:0] tree);
        logic [WAYS-1:0] ext;
        int              node;
        ext  = {tree, 1'b0};
        node = 1;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            node = 2 * node + (ext[node[WAY_W-1:0]] ? 1 : 0);
        end
        return WAY_W'(node - WAYS);
    endfunction

    function automatic logic [TREE_W-1:0] tree_touch(input logic [TREE_W-1:0] tree,
                                                     input logic [WAY_W-1:0]  way);
        logic [WAYS-1:0] ext;
        int              node;
        int              dir;
        ext  = {tree, 1'b0};
        node = 1;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            dir = (int'(way) >> (WAY_W - 1 - lvl)) & 1;
            ext[node[WAY_W-1:0]] = (dir == 0);
            node = 2 * node + dir;
        end
        return TREE_W'(ext >> 1);
    endfunction

    logic [0:0]        state;
    logic [IDX_W-1:0]  init_cnt;

    (* ram_style = "block" *) logic [TREE_W-1:0] mem [SETS];

    logic              accept_p0;
    logic              vld_p1;
    logic              touch_p1;
    logic [IDX_W-1:0]  set_p1;
    logic [WAY_W-1:0]  way_p1;
    logic [TREE_W-1:0] dout_p1;
    logic [TREE_W-1:0] src_tree_p1;
    logic [TREE_W-1:0] new_tree_p1;
    logic [WAY_W-1:0]  victim_p1;

    logic              fwd_vld;
    logic [IDX_W-1:0]  fwd_set;
    logic [TREE_W-1:0] fwd_tree;

    logic              wr_en;
    logic [IDX_W-1:0]  wr_set;
    logic [TREE_W-1:0] wr_tree;

    assign init_done = (state == ST_RUN);
    assign req_ready = init_done;
    assign accept_p0 = req_valid & init_done;

    // S0 -> S1: RAM read of the request set, read-first against the S1 write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_set] <= wr_tree;
        end
        dout_p1 <= mem[req_set];
    end

    // S1: the RAM missed last cycle's write to the same set, so take the forwarded tree.
    assign src_tree_p1 = (fwd_vld && fwd_set == set_p1) ? fwd_tree : dout_p1;
    assign victim_p1   = tree_victim(src_tree_p1);
    assign new_tree_p1 = tree_touch(src_tree_p1, way_p1);

    // A request caught in S1 by reset is dropped without a response.
    assign resp_valid  = vld_p1 & rstn;
    assign resp_victim = resp_valid ? victim_p1 : '0;

    always_comb begin
        wr_en   = 1'b0;
        wr_set  = set_p1;
        wr_tree = new_tree_p1;
        if (state == ST_INIT) begin
            wr_en   = rstn;
            wr_set  = init_cnt;
            wr_tree = '0;
        end else begin
            wr_en = rstn & vld_p1 & touch_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= ST_INIT;
            init_cnt <= '0;
            vld_p1   <= 1'b0;
            touch_p1 <= 1'b0;
            set_p1   <= '0;
            way_p1   <= '0;
            fwd_vld  <= 1'b0;
            fwd_set  <= '0;
            fwd_tree <= '0;
        end else begin
            if (state == ST_INIT) begin
                init_cnt <= init_cnt + 1'b1;
                if (init_cnt == IDX_W'(SETS - 1)) begin
                    state <= ST_RUN;
                end
            end
            vld_p1   <= accept_p0;
            touch_p1 <= req_touch;
            set_p1   <= req_set;
            way_p1   <= req_way;
            fwd_vld  <= vld_p1 & touch_p1;
            fwd_set  <= set_p1;
            fwd_tree <= new_tree_p1;
        end
    end

endmodule

// File: doc/plru_table.md
Name: plru_table

Overview:
- Per-set tree pseudo-LRU state store for an N-way set-associative cache; generalises the fixed 64x8 LRU RAM to parametrised sets/ways.
- Adds an internal read-modify-write pipeline, victim computation, hardware init sweep and same-set hazard forwarding.
- Sits beside the cache tag arrays. The cache controller issues one query/touch per cycle and receives the victim way one cycle later.

Parameters:
- SETS, 64, number of sets; power of 2, >=2; IDX_W = clog2(SETS)
- WAYS, 4, associativity; power of 2, 2..16; WAY_W = clog2(WAYS); tree bits per set = WAYS-1

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous reset, active-low
- init_done  out  1  high once init sweep complete
- req_valid  in  1  request present
- req_ready  out  1  = init_done
- req_set  in  IDX_W  set index
- req_touch  in  1  1: mark req_way MRU after reporting victim; 0: query only
- req_way  in  WAY_W  way accessed (ignored when req_touch=0)
- resp_valid  out  1  victim valid
- resp_victim  out  WAY_W  victim way of req_set, from state before this request's update

Behaviour:
- Storage: SETS x (WAYS-1) block RAM (RAM_STYLE BLOCK), read-first, no reset on array.
- Tree encoding: heap nodes 1..WAYS-1, leaves WAYS..2*WAYS-1 = ways 0..WAYS-1; tree bit k-1 holds node k.
- Victim walk from node 1: bit 0 -> child 2n, bit 1 -> 2n+1; victim = leaf - WAYS.
- Touch way w: each node on root-to-leaf path points away from w. Set to 1 if w's path goes left, 0 if right; off-path bits unchanged.
- Reset (rstn=0 at posedge): init_done=0, req_ready=0, resp_valid=0, resp_victim=0, pipeline/forward regs cleared, init counter=0.
- Reset mid-operation drops in-flight requests with no response and restarts the sweep.
- FSM INIT:
  - Writes all-zero tree to set cnt, cnt++ each cycle, for SETS cycles.
  - After the last set, next cycle -> RUN; init_done=1.
  - Requests are not accepted in INIT.
- FSM RUN:
  - Stays in RUN until reset.
- Pipeline S0 (accept cycle, req_valid & req_ready):
  - RAM read of req_set.
  - set/touch/way latched into S1 regs.
- Pipeline S1 (next cycle):
  - Tree source = forwarded tree if the forward hit condition holds, else RAM dout.
  - resp_victim computed from source; resp_valid=1 for exactly this cycle.
  - If touch: updated tree written to RAM at S1 set.
- Forward register:
  - Holds set and written tree of the previous cycle's S1 touch, with a valid flag.
  - Hit when flag set and set equal.
  - Cleared on any cycle without an S1 touch.
- Latency: 1 cycle request->response. Throughput: 1 request/cycle, no stalls; the consumer cannot backpressure.
- Query-only requests never write RAM.
- Back-to-back touches to the same set must see each preceding update.

Test Plan:
- Reset, count cycles -> init_done rises exactly SETS cycles after rstn deasserts; req_ready=0 throughout; resp_valid=0.
- WAYS=4: query set 5 after init -> resp_victim=0. Touch way 0 on set 5, then query set 5 -> resp_victim=2.
- WAYS=4, set 9, touches 0,2,1,3 issued on consecutive cycles (forward path) -> resp_victim 0,2,1,3. Following query -> 0.
- Same sequence with one idle cycle between each -> identical responses (RAM path).
- Interleaved sets: touch 0 on set 3, touch 0 on set 4, query set 3 -> victims 0,0,2; set 4 state is not disturbed by set 3 forwarding.
- Assert rstn=0 for one cycle while a touch to set 7 is in S1 -> no resp_valid, full init sweep reruns. Query set 7 afterwards -> victim 0.
- Sweep WAYS=2 and WAYS=8, SETS=16:
  - WAYS=8: touch ways 0..7 sequentially -> final query victim 0.
  - WAYS=2: touch way 1 -> victim 0.
